// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the symmetric FIR MAC:
//     - fir_state_t  : FSM state encoding (IDLE, ACCUM, HOLD)
//     - DEFAULT_H    : number of distinct coefficients in the default set
//     - DEFAULT_COEF : default half-filter coefficients c[0..15] (sum over all
//                      31 taps = 1028, scaled by 2^10)
//     - acc_width()  : accumulator width that cannot overflow for H taps
// -----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } fir_state_t;

  localparam int DEFAULT_H = 16;

  localparam int unsigned DEFAULT_COEF [DEFAULT_H] = '{
    3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68
  };

  // Pre-add is data_w+1 bits, product adds coef_w bits, and summing h
  // products needs $clog2(h) more bits of headroom.
  function automatic int acc_width(input int data_w, input int coef_w, input int h);
    return data_w + 1 + coef_w + $clog2(h);
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// -----------------------------------------------------------------------------
// fir_coef_rom
//   Combinational coefficient lookup: tap index k -> c[k].
//   Indices at or beyond the half-length H (and beyond the default set)
//   return 0, so the drain cycle of the MAC contributes nothing.
// Ports:
//   k    in  [K_W-1:0]    tap index (0..H, H being the drain cycle)
//   coef out [COEF_W-1:0] coefficient for that tap
// -----------------------------------------------------------------------------
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter  int TAPS   = 31,
  parameter  int COEF_W = 8,
  localparam int H      = (TAPS + 1) / 2,
  localparam int K_W    = $clog2(H + 1)
) (
  input  logic [K_W-1:0]    k,
  output logic [COEF_W-1:0] coef
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    coef = '0;
    for (int i = 0; i < DEFAULT_H; i++) begin
      if (i < H && k == K_W'(i)) begin
        coef = COEF_W'(DEFAULT_COEF[i]);
      end
    end
  end

endmodule

// File: rtl/fir_symmetric_mac.sv
// -----------------------------------------------------------------------------
// fir_symmetric_mac
//   Odd-length symmetric FIR filter using a single multiplier. Each accepted
//   sample is shifted into the delay line, then H=(TAPS+1)/2 MAC cycles fold
//   mirrored taps through a pre-adder (centre tap alone), followed by one
//   cycle that registers the scaled result. The result is held until the
//   consumer takes it; only then is a new sample accepted.
//
// Optional feature (macro FIR_SATURATE_EN):
//   defined   : shifted result above 2^DATA_W-1 clamps to 2^DATA_W-1
//   undefined : output is the low DATA_W bits of the shifted result (wrap)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   in_sample is valid
//   in_ready   out  sample accepted this cycle (IDLE only)
//   in_sample  in   [DATA_W-1:0] new unsigned sample
//   out_valid  out  out_sample is valid (HOLD only)
//   out_ready  in   consumer accepts out_sample
//   out_sample out  [DATA_W-1:0] filtered unsigned sample
// -----------------------------------------------------------------------------
module fir_symmetric_mac
  import fir_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int COEF_W     = 8,
  parameter int TAPS       = 31,
  parameter int COEF_SHIFT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample
);

  localparam int H     = (TAPS + 1) / 2;
  localparam int K_W   = $clog2(H + 1);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, H);

  fir_state_t          state;
  fir_state_t          state_next;
  logic [K_W-1:0]      k;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   x [TAPS];

  logic [COEF_W-1:0]   coef;
  logic [DATA_W-1:0]   x_near;
  logic [DATA_W-1:0]   x_far;
  logic [DATA_W:0]     pre_add;
  logic [ACC_W-1:0]    product;
  logic [DATA_W-1:0]   result;
  logic                accept;
  logic                mac_done;

  fir_coef_rom #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_rom (
    .k    (k),
    .coef (coef)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  // k == H is the drain cycle: all H products are already in acc.
  assign mac_done  = (k == K_W'(H));

  // Select the mirrored tap pair for index k. The centre tap has no partner,
  // so its far operand is zero and the pre-add passes x[k] through.
  always_comb begin
    x_near = '0;
    x_far  = '0;
    for (int i = 0; i < H; i++) begin
      if (k == K_W'(i)) begin
        x_near = x[i];
        x_far  = (i == H - 1) ? '0 : x[TAPS-1-i];
      end
    end
  end

  assign pre_add = {1'b0, x_near} + {1'b0, x_far};
  assign product = ACC_W'(coef) * ACC_W'(pre_add);

`ifdef FIR_SATURATE_EN
  logic [ACC_W-1:0] shifted;
  assign shifted = acc >> COEF_SHIFT;
  assign result  = (|shifted[ACC_W-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];
`else
  assign result  = DATA_W'(acc >> COEF_SHIFT);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = ACCUM;
      ACCUM:   if (mac_done)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: the delay line is a small register array that must read as zero
  // after reset, so it is cleared explicitly rather than left to power-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      acc        <= '0;
      k          <= '0;
      out_sample <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            x[0] <= in_sample;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        ACCUM: begin
          if (mac_done) begin
            out_sample <= result;
          end else begin
            acc <= acc + product;
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_symmetric_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_symmetric_mac
//   Self-checking bench: a direct-form convolution over a history array of
//   accepted samples predicts each output; impulse, DC, overflow,
//   backpressure, random and mid-operation reset scenarios are exercised.
// -----------------------------------------------------------------------------
module tb_fir_symmetric_mac;

  localparam int DATA_W = 10;
  localparam int TAPS   = 31;
  localparam int H      = 16;
  localparam int MAXV   = 1023;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sample;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int coef_tab [H] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
  int hist [TAPS];

  fir_symmetric_mac dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int s);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endfunction

  // Full symmetric impulse response applied by plain convolution.
  function automatic int model_out();
    longint sum = 0;
    longint res;
    for (int i = 0; i < TAPS; i++)
      sum += longint'(coef_tab[(i < H) ? i : TAPS - 1 - i]) * hist[i];
    res = sum >> 10;
`ifdef FIR_SATURATE_EN
    if (res > MAXV) res = MAXV;
`else
    res = res % (MAXV + 1);
`endif
    return int'(res);
  endfunction

  // Waits for in_ready, offers one sample and returns at the negedge after
  // the accepting edge.
  task automatic accept(input int s);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_sample = DATA_W'(s);
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    model_push(s);
  endtask

  task automatic run_sample(input int s, input bit stall, output int got);
    int lat = 0;
    int exp_v;
    logic [DATA_W-1:0] held;
    out_ready = !stall;
    accept(s);
    exp_v = model_out();
    // One negedge after acceptance counts as zero elapsed edges.
    while (!out_valid && lat < 40) begin
      if (in_ready) check("ready_in_accum", 1, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, H + 1);
    got = int'(out_sample);
    check("out_sample", got, exp_v);
    if (stall) begin
      held = out_sample;
      for (int c = 0; c < 5; c++) begin
        in_sample = DATA_W'($urandom_range(0, MAXV));
        in_valid  = 1'b1;
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_sample, held);
        check("stall_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("released_valid", out_valid, 0);
    check("released_ready", in_ready, 1);
  endtask

  task automatic run_impulse(input string tag);
    int got;
    int exp_c;
    for (int n = 0; n < TAPS; n++) begin
      run_sample((n == 0) ? MAXV : 0, 1'b0, got);
      if (n < H) exp_c = (MAXV * coef_tab[n]) / 1024;
      else       exp_c = (MAXV * coef_tab[TAPS - 1 - n]) / 1024;
      check(tag, got, exp_c);
    end
    run_sample(0, 1'b0, got);
    check({tag, "_tail"}, got, 0);
  endtask

  initial begin
    int got;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    reset = 1'b0;
    @(negedge clk);

    // Impulse response walks out the coefficient set and back.
    run_impulse("impulse");

    // DC gain: sum of coefficients is 1028.
    for (int n = 0; n < TAPS; n++) run_sample(1000, 1'b0, got);
    check("dc_1000", got, 1003);

    // Full-scale input exceeds the output range.
    for (int n = 0; n < TAPS; n++) run_sample(MAXV, 1'b0, got);
`ifdef FIR_SATURATE_EN
    check("overflow", got, 1023);
`else
    check("overflow", got, 2);
`endif

    // Backpressure, then random traffic with occasional stalls.
    run_sample(int'($urandom_range(0, MAXV)), 1'b1, got);
    for (int n = 0; n < 40; n++)
      run_sample(int'($urandom_range(0, MAXV)), ($urandom_range(0, 3) == 0), got);

    // Reset in the 8th accumulate cycle aborts the sample.
    out_ready = 1'b1;
    accept(MAXV);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sample", out_sample, 0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("abort_no_output", out_valid, 0);
    run_impulse("impulse_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fir_symmetric_mac.md
FIR_SYMMETRIC_MAC -- requirements
Module: fir_symmetric_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 10, the unsigned sample width in and out.
REQ-002 SHALL have parameter COEF_W, default 8, the unsigned coefficient width.
REQ-003 SHALL have parameter TAPS, default 31, the filter length; it SHALL be odd and at least 3.
REQ-004 SHALL have parameter COEF_SHIFT, default 10, the output right-shift (coefficients scaled by 2^COEF_SHIFT).
REQ-005 SHALL have port clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning in_sample is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-009 SHALL have port in_sample, input, DATA_W, the new unsigned sample.
REQ-010 SHALL have port out_valid, output, 1, meaning out_sample is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts out_sample.
REQ-012 SHALL have port out_sample, output, DATA_W, the filtered unsigned sample.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ACCUM, HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-015 On in_valid&&in_ready, SHALL shift in_sample into delay line x[0] (x[k] moves to x[k+1], x[TAPS-1] discarded), clear the accumulator and enter ACCUM.
REQ-016 ACCUM SHALL last H=(TAPS+1)/2 cycles, with k=0..H-1, one multiply per cycle.
- k<H-1: acc += c[k]*(x[k]+x[TAPS-1-k]).
- k=H-1 (centre tap): acc += c[k]*x[k].
REQ-017 The pre-add SHALL be DATA_W+1 bits wide; acc SHALL be DATA_W+1+COEF_W+$clog2(H) bits wide, so no intermediate overflow occurs.
REQ-018 After the last ACCUM cycle, SHALL register out_sample from acc>>COEF_SHIFT (see REQ-026) and enter HOLD.
- Latency: acceptance at edge N gives out_valid=1 after edge N+H+1.
REQ-019 In HOLD, out_sample and out_valid SHALL remain stable until out_valid&&out_ready, then enter IDLE; in_ready returns the next cycle, with no same-cycle bypass.
REQ-020 in_valid in ACCUM or HOLD SHALL be ignored, and the delay line SHALL not change.
REQ-021 Coefficients c[0..H-1] SHALL be constant.
- Default set: 3,4,6,8,12,17,23,29,36,43,50,56,61,65,67,68 (sum over all taps = 1028).

Reset
REQ-022 Reset SHALL force IDLE, clear the delay line and accumulator to 0, and drive out_valid=0, out_sample=0, in_ready=1.
REQ-023 Reset asserted mid-ACCUM or in HOLD SHALL abort the operation; no output SHALL be produced for the aborted sample.

Configuration
REQ-024 Macro FIR_SATURATE_EN SHALL select the output overflow policy.
REQ-025 With FIR_SATURATE_EN defined, a shifted result above 2^DATA_W-1 SHALL clamp to 2^DATA_W-1.
REQ-026 Without FIR_SATURATE_EN, out_sample SHALL be the low DATA_W bits of the shifted result (wrap).

Structure
REQ-027 Package fir_pkg SHALL hold the FSM state enum, the default coefficient array, and a function computing the accumulator width.
REQ-028 Sub-module fir_coef_rom SHALL map tap index k to c[k] combinationally, parameterised on TAPS and COEF_W.

Verification
REQ-029 Impulse test: after reset, send 1023 then 30 zeros with out_ready=1 -> outputs floor(1023*c[k]/1024) for k=0..15 then back to 0: 2,3,5,7,11,16,...,67,66,...,2.
REQ-030 DC test: send 31 samples of 1000 -> 31st output = floor(1000*1028/1024) = 1003.
REQ-031 Overflow test: send 31 samples of 1023 -> 31st output = 1023 with FIR_SATURATE_EN, 2 without.
REQ-032 Latency/backpressure test: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_sample stable, in_ready=0 throughout, offered samples ignored; H+1=17 cycles from accept to out_valid.
REQ-033 Reset test: assert reset on the 8th ACCUM cycle -> next cycle state IDLE, out_valid=0, in_ready=1; a following impulse reproduces the REQ-029 response exactly.
